// File: rtl/conff_pkg.sv
// Shared definitions for the conditional-branch (CON flip-flop) unit:
// condition-code encoding and handshake FSM state encoding.
package conff_pkg;

    // 3-bit condition field values decoded from the instruction register
    localparam logic [2:0] COND_NEVER   = 3'd0;
    localparam logic [2:0] COND_ALWAYS  = 3'd1;
    localparam logic [2:0] COND_ZERO    = 3'd2;
    localparam logic [2:0] COND_NONZERO = 3'd3;
    localparam logic [2:0] COND_PLUS    = 3'd4;
    localparam logic [2:0] COND_MINUS   = 3'd5;
    localparam logic [2:0] COND_POS     = 3'd6;
    localparam logic [2:0] COND_LE      = 3'd7;

    // Decision handshake: IDLE = nothing pending, VALID = decision awaiting ack
    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

endpackage

// File: rtl/conff_cond_eval.sv
// Combinational condition evaluator: tests a two's-complement operand
// against a 3-bit condition code and reports zero/negative status.
module conff_cond_eval
    import conff_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       c,
    input  logic [WIDTH-1:0] busin,
    output logic             result,
    output logic             zero,
    output logic             negative
);

    // Decode the condition against the operand's zero/sign status
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        result   = 1'b0;
        zero     = (busin == '0);
        negative = busin[WIDTH-1];
        case (c)
            COND_NEVER:   result = 1'b0;
            COND_ALWAYS:  result = 1'b1;
            COND_ZERO:    result = zero;
            COND_NONZERO: result = !zero;
            COND_PLUS:    result = !negative;
            COND_MINUS:   result = negative;
            COND_POS:     result = !zero && !negative;
            COND_LE:      result = zero || negative;
            default:      result = 1'b0;
        endcase
    end

endmodule

// File: rtl/conff_unit.sv
// Conditional-branch unit: registers the branch decision on each evaluate
// strobe, tracks decision validity with an ack handshake, keeps sticky
// operand flags, detects overrun and counts evaluations/taken branches.
module conff_unit
    import conff_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int IR_WIDTH  = 32,
    parameter int C2_LSB    = 0,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 con_in,
    input  logic [WIDTH-1:0]     busin,
    input  logic [IR_WIDTH-1:0]  ir,
    input  logic                 con_ack,
    input  logic                 cnt_clear,
    output logic                 con_out,
    output logic                 con_valid,
    output logic                 flag_z,
    output logic                 flag_n,
    output logic                 overrun,
    output logic [CNT_WIDTH-1:0] eval_count,
    output logic [CNT_WIDTH-1:0] taken_count
);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] cond;
    logic       eval_result;
    logic       eval_zero;
    logic       eval_neg;

    // Only the condition field of ir matters; the rest is consumed here on purpose.
    logic       unused_ir;
    assign unused_ir = ^ir;

    assign cond = ir[C2_LSB +: 3];

    conff_cond_eval #(
        .WIDTH (WIDTH)
    ) u_cond_eval (
        .c        (cond),
        .busin    (busin),
        .result   (eval_result),
        .zero     (eval_zero),
        .negative (eval_neg)
    );

    // Handshake state register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Handshake next-state: a new strobe always (re)arms VALID; ack alone retires it
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (con_in) state_nxt = VALID;
            VALID:   if (con_ack && !con_in) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // 1-bit enum decoded straight from the state flop, so still a register output
    assign con_valid = (state == VALID);

    // Decision and operand flags: load on strobe, hold otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            con_out <= 1'b0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
        end else if (con_in) begin
            con_out <= eval_result;
            flag_z  <= eval_zero;
            flag_n  <= eval_neg;
        end
    end

    // Sticky overrun: a strobe replaced a decision nobody acknowledged; clear wins over set
    always_ff @(posedge clk) begin
        if (reset || cnt_clear)                       overrun <= 1'b0;
        else if (state == VALID && con_in && !con_ack) overrun <= 1'b1;
    end

    // Saturating statistics counters; clear wins over increment
    always_ff @(posedge clk) begin
        if (reset || cnt_clear) begin
            eval_count  <= '0;
            taken_count <= '0;
        end else if (con_in) begin
            if (eval_count != '1)
                eval_count <= eval_count + CNT_WIDTH'(1);
            if (eval_result && taken_count != '1)
                taken_count <= taken_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_conff_unit.sv
// Self-checking bench for conff_unit: table-driven condition sweep on a
// default instance plus directed handshake/overrun/reset/saturation sequences;
// a second instance uses CNT_WIDTH=4 and C2_LSB=19.
module tb_conff_unit;

    logic        clk = 1'b0;
    logic        reset;

    // default-parameter instance
    logic        con_in, con_ack, cnt_clear;
    logic [31:0] busin, ir;
    logic        con_out, con_valid, flag_z, flag_n, overrun;
    logic [15:0] eval_count, taken_count;

    // small-counter, shifted-field instance
    logic        con_in2, con_ack2, cnt_clear2;
    logic [31:0] busin2, ir2;
    logic        con_out2, con_valid2, flag_z2, flag_n2, overrun2;
    logic [3:0]  eval_count2, taken_count2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    conff_unit dut (
        .clk         (clk),
        .reset       (reset),
        .con_in      (con_in),
        .busin       (busin),
        .ir          (ir),
        .con_ack     (con_ack),
        .cnt_clear   (cnt_clear),
        .con_out     (con_out),
        .con_valid   (con_valid),
        .flag_z      (flag_z),
        .flag_n      (flag_n),
        .overrun     (overrun),
        .eval_count  (eval_count),
        .taken_count (taken_count)
    );

    conff_unit #(
        .WIDTH     (32),
        .IR_WIDTH  (32),
        .C2_LSB    (19),
        .CNT_WIDTH (4)
    ) dut_s (
        .clk         (clk),
        .reset       (reset),
        .con_in      (con_in2),
        .busin       (busin2),
        .ir          (ir2),
        .con_ack     (con_ack2),
        .cnt_clear   (cnt_clear2),
        .con_out     (con_out2),
        .con_valid   (con_valid2),
        .flag_z      (flag_z2),
        .flag_n      (flag_n2),
        .overrun     (overrun2),
        .eval_count  (eval_count2),
        .taken_count (taken_count2)
    );

    typedef struct {
        logic [31:0] busin;
        logic [7:0]  exp_mask;   // bit c = expected con_out for condition c
        logic        exp_z;
        logic        exp_n;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // advance one edge; outputs are sampled 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // busin, {c7..c0 expected}, z, n
        vecs[0] = '{32'h0000_0000, 8'h96, 1'b1, 1'b0};
        vecs[1] = '{32'h0000_0001, 8'h5A, 1'b0, 1'b0};
        vecs[2] = '{32'h8000_0000, 8'hAA, 1'b0, 1'b1};
        vecs[3] = '{32'h7FFF_FFFF, 8'h5A, 1'b0, 1'b0};
        vecs[4] = '{32'hFFFF_FFFF, 8'hAA, 1'b0, 1'b1};

        reset = 1'b1;
        con_in = 0; con_ack = 0; cnt_clear = 0; busin = '0; ir = '0;
        con_in2 = 0; con_ack2 = 0; cnt_clear2 = 0; busin2 = '0; ir2 = '0;
        step(); step();
        reset = 1'b0;
        check("reset con_out", con_out, 0);
        check("reset con_valid", con_valid, 0);
        check("reset flags", {flag_z, flag_n}, 0);
        check("reset overrun", overrun, 0);
        check("reset counts", {eval_count, taken_count}, 0);

        // condition sweep, acknowledged every cycle so no overrun
        con_in = 1; con_ack = 1;
        for (int v = 0; v < 5; v++) begin
            for (int c = 0; c < 8; c++) begin
                busin = vecs[v].busin;
                ir    = {29'h1ABC_DEF0 >> 3, 3'(c)};
                step();
                check($sformatf("sweep con_out c=%0d busin=%h", c, vecs[v].busin),
                      con_out, vecs[v].exp_mask[c]);
                check($sformatf("sweep flags busin=%h", vecs[v].busin),
                      {flag_z, flag_n}, {vecs[v].exp_z, vecs[v].exp_n});
            end
        end
        check("sweep valid", con_valid, 1);
        check("sweep overrun", overrun, 0);
        check("sweep eval_count", eval_count, 40);
        check("sweep taken_count", taken_count, 20);

        // ack only: retire, decision and flags hold with changing busin
        con_in = 0; busin = 32'h0000_0000; ir = 32'd0;
        step();
        check("ack idle valid", con_valid, 0);
        check("hold con_out", con_out, 1);
        check("hold flags", {flag_z, flag_n}, 2'b01);

        // con_in then ack two cycles later: valid exactly 2 cycles
        con_in = 1; con_ack = 0; ir = 32'd1; busin = 32'd9;
        step();
        con_in = 0;
        check("hs valid c1", con_valid, 1);
        step();
        check("hs valid c2", con_valid, 1);
        con_ack = 1;
        step();
        con_ack = 0;
        check("hs valid dropped", con_valid, 0);
        check("hs overrun", overrun, 0);

        // ack in IDLE ignored, then strobe with same-cycle ack in VALID
        con_ack = 1;
        step();
        check("idle ack", con_valid, 0);
        con_in = 1; con_ack = 0;
        step();
        con_ack = 1;
        step();
        check("resample valid", con_valid, 1);
        check("resample overrun", overrun, 0);
        con_in = 0;
        step();
        check("resample retire", con_valid, 0);

        // two strobes without ack -> overrun; cnt_clear clears it only
        con_in = 1; con_ack = 0;
        step();
        check("ovr first", overrun, 0);
        step();
        check("ovr second", overrun, 1);
        con_in = 0; cnt_clear = 1;
        step();
        cnt_clear = 0;
        check("clr overrun", overrun, 0);
        check("clr valid kept", con_valid, 1);
        check("clr counts", {eval_count, taken_count}, 0);
        check("clr con_out kept", con_out, 1);

        // build counts 5/3 ending with con_out=1, then reset mid-VALID
        con_in = 1; con_ack = 1; ir = 32'd0;
        step(); step();
        ir = 32'd1;
        step(); step(); step();
        check("pre-reset counts", {eval_count, taken_count}, {16'd5, 16'd3});
        check("pre-reset out", {con_out, con_valid}, 2'b11);
        reset = 1; cnt_clear = 0; con_ack = 0;
        step();
        reset = 0; con_in = 0;
        check("mid reset out", {con_out, con_valid, flag_z, flag_n, overrun}, 0);
        check("mid reset counts", {eval_count, taken_count}, 0);

        // shifted field: ir[21:19]=3 (nonzero); low bits hold 7 as a decoy
        con_in2 = 1; con_ack2 = 1;
        ir2 = (32'd3 << 19) | 32'd7; busin2 = 32'd0;
        step();
        check("s nz busin0", con_out2, 0);
        busin2 = 32'd5;
        step();
        check("s nz busin5", con_out2, 1);
        check("s counts", {eval_count2, taken_count2}, {4'd2, 4'd1});

        // 20 always-taken strobes saturate both 4-bit counters
        ir2 = 32'd1 << 19;
        for (int i = 0; i < 20; i++) step();
        check("s sat eval", eval_count2, 4'hF);
        check("s sat taken", taken_count2, 4'hF);
        cnt_clear2 = 1;
        step();
        cnt_clear2 = 0; con_in2 = 0;
        check("s clear beats inc", {eval_count2, taken_count2}, 0);
        check("s clear con_out", con_out2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conff_unit.md
# conff_unit

Parametrised conditional-branch unit (CON flip-flop) for the datapath control path. On a control-unit strobe it decodes the instruction's 3-bit condition field and evaluates the bus operand against it, registering the branch decision for the PC-update step. It also tracks decision validity with an acknowledge handshake, sticky operand flags, overrun detection and saturating evaluation/taken counters for performance monitoring.

## Interface
- WIDTH, 32: bus operand width (≥2).
- IR_WIDTH, 32: instruction register width.
- C2_LSB, 0: LSB index of the 3-bit condition field; field is ir[C2_LSB+2:C2_LSB].
- CNT_WIDTH, 16: width of each statistics counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- con_in  in  1  evaluate strobe from control unit.
- busin  in  WIDTH  operand under test (two's complement).
- ir  in  IR_WIDTH  current instruction.
- con_ack  in  1  control unit has consumed con_out.
- cnt_clear  in  1  synchronous clear of counters and overrun.
- con_out  out  1  registered branch decision.
- con_valid  out  1  decision pending consumption.
- flag_z  out  1  last evaluated operand was zero.
- flag_n  out  1  last evaluated operand was negative.
- overrun  out  1  sticky: new evaluation overwrote an unacknowledged one.
- eval_count  out  CNT_WIDTH  evaluations since clear, saturating.
- taken_count  out  CNT_WIDTH  evaluations with result 1, saturating.

## Operation
- Condition codes c: 0 never, 1 always, 2 zero (busin==0), 3 nonzero, 4 plus (busin[WIDTH-1]==0), 5 minus (busin[WIDTH-1]==1), 6 positive (>0: not zero and not negative), 7 non-positive (≤0).
- On con_in: con_out ← cond(c, busin); flag_z ← (busin==0); flag_n ← busin[WIDTH-1]; eval_count += 1; taken_count += 1 if result 1. Without con_in, con_out/flags hold.
- Handshake FSM, states IDLE (con_valid=0) and VALID (con_valid=1):
  - IDLE, con_in → VALID.
  - VALID, con_ack & !con_in → IDLE.
  - VALID, con_in (any con_ack) → VALID with new result; if con_ack=0 same cycle, overrun ← 1.
  - con_ack in IDLE ignored.
- Counters saturate at all-ones, never wrap.
- cnt_clear: eval_count, taken_count, overrun ← 0; clear has priority over simultaneous increment/overrun set. cnt_clear does not affect con_out, con_valid, flags.
- reset: con_out 0, con_valid 0, flag_z 0, flag_n 0, overrun 0, both counters 0; overrides all other inputs, including mid-VALID.

## Timing
- Latency: busin/ir sampled at edge where con_in=1; con_out, con_valid, flags, counters valid the following cycle (1-cycle).
- busin and ir must be stable only in the con_in cycle.
- con_ack in cycle N drops con_valid after edge N.
- Back-to-back con_in every cycle permitted; each updates con_out; overrun set from second if unacknowledged.
- All outputs are direct register outputs; no combinational input→output paths.

## Structure
- Package conff_pkg: 3-bit condition-code localparams (COND_NEVER…COND_LE), FSM state encoding (IDLE, VALID).
- Sub-module conff_cond_eval: combinational (c, busin) → result, zero, negative; parametrised by WIDTH. Top holds FSM, registers, counters.

## Test plan
- Reset mid-VALID with con_out=1, counters 5/3 → next cycle all outputs 0.
- WIDTH=32, sweep c=0..7 with busin 0, 1, 0x8000_0000, 0x7FFF_FFFF → con_out matches code table (e.g. c=6,busin=0 → 0; c=7,busin=0x8000_0000 → 1); flag_z/flag_n correct.
- con_in then con_ack two cycles later → con_valid 1 for exactly 2 cycles, overrun 0; con_in with con_ack same cycle in VALID → stays VALID, overrun 0.
- con_in two consecutive cycles, no ack → overrun 1 after second edge; cnt_clear → overrun 0, con_valid still 1.
- CNT_WIDTH=4, 20 con_in with c=1 → eval_count=taken_count=15 (saturated); cnt_clear together with con_in → both 0.
- C2_LSB=19, ir[21:19]=3, busin=0 then 5 → con_out 0 then 1; taken_count 1, eval_count 2.
